// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED pattern scheduler.
// The priority helper works on a fixed maximum width; callers cast to their own N_REQ.
package led_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   localparam int LED_W = 4;
   localparam int MAX_REQ = 32;
   localparam logic PHASE_ON = 1'b1;

   // Later (higher-index) set bits overwrite earlier ones, so the highest set bit survives.
   function automatic logic [MAX_REQ-1:0] highest_onehot(input logic [MAX_REQ-1:0] vec);
      logic [MAX_REQ-1:0] result;
      result = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (vec[i]) begin
            result = '0;
            result[i] = 1'b1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running display tick prescaler: one-cycle pulse every TICK_DIV sys_clk cycles.
// Deliberately independent of arbitration so tick spacing never jitters on regrants.
module led_tick_gen #(
   parameter int TICK_DIV = 20_000_000
) (
   input  logic sys_clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pattern_sched.sv
// Fixed-priority scheduler for the user LED bank: grants one requester, holds it
// for a readable minimum time, and drives its pattern steady or blinking.
module led_pattern_sched
   import led_sched_pkg::*;
#(
   parameter int TICK_DIV = 20_000_000,
   parameter int N_REQ = 3,
   parameter int MIN_HOLD_TICKS = 5,
   parameter int BLINK_TICKS = 5,
   parameter logic [LED_W-1:0] IDLE_PATTERN = 4'b0000
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [LED_W*N_REQ-1:0] pattern,
   input  logic [N_REQ-1:0]       blink,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic                   tick,
   output logic [LED_W-1:0]       led
);

   localparam int HOLD_W = (MIN_HOLD_TICKS > 0) ? $clog2(MIN_HOLD_TICKS + 1) : 1;
   localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_TICKS);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

   state_t state_q, state_d;

   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [LED_W-1:0]  pat_q, pat_d;
   logic [LED_W-1:0]  led_q, led_d;
   logic              blink_q, blink_d;
   logic              phase_q, phase_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [BLK_W-1:0]  bcnt_q, bcnt_d;

   logic [N_REQ-1:0]  winner;
   logic              satisfied;
   logic              owner_req;
   logic              higher_pending;
   logic              load;
   logic              go_idle;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .sys_clk (sys_clk),
      .rst     (rst),
      .tick    (tick)
   );

   assign winner    = N_REQ'(highest_onehot(MAX_REQ'(req)));
   assign satisfied = (hold_q == HOLD_MAX);
   assign owner_req = |(req & grant_q);

   // A request strictly above the current owner's index may preempt once the hold expires.
   always_comb begin
      logic above;
      above = 1'b0;
      higher_pending = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (above && req[i]) begin
            higher_pending = 1'b1;
         end
         if (grant_q[i]) begin
            above = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      go_idle = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = SHOW;
               load    = 1'b1;
            end
         end
         SHOW: begin
            if (satisfied) begin
               if (!owner_req) begin
                  if (|req) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     go_idle = 1'b1;
                  end
               end else if (higher_pending) begin
                  load = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A (re)grant wins over a same-cycle tick, so the new owner starts with a clean hold and phase.
   always_comb begin
      grant_d = grant_q;
      pat_d   = pat_q;
      blink_d = blink_q;
      phase_d = phase_q;
      hold_d  = hold_q;
      bcnt_d  = bcnt_q;
      led_d   = IDLE_PATTERN;
      if (load) begin
         grant_d = winner;
         for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
               pat_d   = pattern[LED_W*i +: LED_W];
               blink_d = blink[i];
            end
         end
         phase_d = PHASE_ON;
         hold_d  = '0;
         bcnt_d  = '0;
      end else if (go_idle) begin
         grant_d = '0;
         blink_d = 1'b0;
         phase_d = PHASE_ON;
         hold_d  = '0;
         bcnt_d  = '0;
      end else if (state_q == SHOW && tick) begin
         if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
         end
         if (bcnt_q == BLK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + BLK_W'(1);
         end
      end
      if (state_d == IDLE) begin
         led_d = IDLE_PATTERN;
      end else if (blink_d && (phase_d != PHASE_ON)) begin
         led_d = '0;
      end else begin
         led_d = pat_d;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         grant_q <= '0;
         pat_q   <= '0;
         blink_q <= 1'b0;
         phase_q <= PHASE_ON;
         hold_q  <= '0;
         bcnt_q  <= '0;
         led_q   <= IDLE_PATTERN;
      end else begin
         grant_q <= grant_d;
         pat_q   <= pat_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
         hold_q  <= hold_d;
         bcnt_q  <= bcnt_d;
         led_q   <= led_d;
      end
   end

   assign grant = grant_q;
   assign busy  = |grant_q;
   assign led   = led_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Self-checking bench for led_pattern_sched: directed scenarios then random traffic,
// all compared against a tick-counting reference model of the owner and its display.
module tb_led_pattern_sched;

   localparam int TICK_DIV = 4;
   localparam int N_REQ = 3;
   localparam int MIN_HOLD = 2;
   localparam int BLINK_T = 1;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [11:0] pattern;
   logic [2:0]  blink;
   logic [2:0]  grant;
   logic        busy;
   logic        tick;
   logic [3:0]  led;

   int checks;
   int errors;
   int tick_count;

   // Reference model state: owner index (-1 = none) and ticks seen since its grant.
   int         m_owner;
   int         m_ticks;
   int         m_cyc;
   logic [3:0] m_pat;
   logic       m_blink;

   always #5 sys_clk = ~sys_clk;

   led_pattern_sched #(
      .TICK_DIV       (TICK_DIV),
      .N_REQ          (N_REQ),
      .MIN_HOLD_TICKS (MIN_HOLD),
      .BLINK_TICKS    (BLINK_T),
      .IDLE_PATTERN   (4'b0000)
   ) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .req     (req),
      .pattern (pattern),
      .blink   (blink),
      .grant   (grant),
      .busy    (busy),
      .tick    (tick),
      .led     (led)
   );

   task automatic modelReset();
      m_owner = -1;
      m_ticks = 0;
      m_cyc   = 0;
      m_pat   = 4'b0000;
      m_blink = 1'b0;
   endtask

   task automatic modelGrant(input int idx);
      m_owner = idx;
      m_pat   = pattern[4*idx +: 4];
      m_blink = blink[idx];
      m_ticks = 0;
   endtask

   task automatic modelStep();
      bit tick_seen;
      int top;
      if (rst) begin
         modelReset();
      end else begin
         tick_seen = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
         m_cyc++;
         top = -1;
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) top = i;
         end
         if (m_owner < 0) begin
            if (top >= 0) modelGrant(top);
         end else if (m_ticks >= MIN_HOLD && !req[m_owner]) begin
            if (top >= 0) modelGrant(top);
            else m_owner = -1;
         end else if (m_ticks >= MIN_HOLD && top > m_owner) begin
            modelGrant(top);
         end else if (tick_seen) begin
            m_ticks++;
         end
      end
   endtask

   function automatic logic [3:0] expLed();
      if (m_owner < 0) return 4'b0000;
      if (m_blink && ((m_ticks / BLINK_T) % 2 == 1)) return 4'b0000;
      return m_pat;
   endfunction

   function automatic logic [2:0] expGrant();
      if (m_owner < 0) return 3'b000;
      return 3'(1 << m_owner);
   endfunction

   function automatic logic expTick();
      return ((m_cyc % TICK_DIV) == TICK_DIV - 1);
   endfunction

   task automatic checkOutput(input string tag);
      checks++;
      assert (led === expLed()) else begin
         errors++;
         $error("[TB] FAIL %s_led got %b exp %b", tag, led, expLed());
      end
      checks++;
      assert (grant === expGrant()) else begin
         errors++;
         $error("[TB] FAIL %s_grant got %b exp %b", tag, grant, expGrant());
      end
      checks++;
      assert (busy === (m_owner >= 0)) else begin
         errors++;
         $error("[TB] FAIL %s_busy got %b exp %b", tag, busy, (m_owner >= 0));
      end
      checks++;
      assert (tick === expTick()) else begin
         errors++;
         $error("[TB] FAIL %s_tick got %b exp %b", tag, tick, expTick());
      end
   endtask

   task automatic checkValue(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] r, input logic [11:0] p,
                                input logic [2:0] b, input int n, input string tag);
      req     = r;
      pattern = p;
      blink   = b;
      repeat (n) begin
         @(posedge sys_clk);
         modelStep();
         @(negedge sys_clk);
         checkOutput(tag);
         if (tick === 1'b1) tick_count++;
      end
   endtask

   initial begin
      logic [2:0]  r_req;
      logic [11:0] r_pat;
      logic [2:0]  r_blk;
      checks     = 0;
      errors     = 0;
      tick_count = 0;
      req        = 3'b000;
      pattern    = 12'h000;
      blink      = 3'b000;
      rst        = 1'b1;
      modelReset();
      repeat (5) begin
         @(negedge sys_clk);
         checkOutput("reset");
      end
      rst = 1'b0;

      applyStimulus(3'b000, 12'h000, 3'b000, 1000, "idle");
      checkValue("tick_count", tick_count, 250);

      applyStimulus(3'b001, 12'h005, 3'b000, 1, "single");
      checkValue("single_led", int'(led), 5);
      checkValue("single_grant", int'(grant), 1);
      applyStimulus(3'b000, 12'h005, 3'b000, 12, "release");
      checkValue("release_grant", int'(grant), 0);

      applyStimulus(3'b001, 12'h005, 3'b000, 1, "pre_own");
      applyStimulus(3'b101, 12'hC05, 3'b000, 14, "preempt");
      checkValue("preempt_grant", int'(grant), 4);
      checkValue("preempt_led", int'(led), 12);
      applyStimulus(3'b000, 12'hC05, 3'b000, 12, "drop2");

      applyStimulus(3'b010, 12'h0F0, 3'b010, 1, "blink_grant");
      checkValue("blink_first_led", int'(led), 15);
      applyStimulus(3'b010, 12'h0F0, 3'b010, 16, "blink");

      #1 rst = 1'b1;
      modelReset();
      #1;
      checkValue("rst_led", int'(led), 0);
      checkValue("rst_grant", int'(grant), 0);
      checkOutput("rst_async");
      @(negedge sys_clk);
      rst = 1'b0;
      applyStimulus(3'b010, 12'h0F0, 3'b010, 1, "rst_regrant");
      checkValue("rst_regrant_grant", int'(grant), 2);
      applyStimulus(3'b010, 12'h0F0, 3'b010, 10, "post_rst");
      applyStimulus(3'b000, 12'h0F0, 3'b000, 12, "drop1");

      applyStimulus(3'b001, 12'h005, 3'b000, 1, "pat_own");
      applyStimulus(3'b001, 12'h003, 3'b000, 10, "pat_change");
      checkValue("pat_hold_led", int'(led), 5);
      applyStimulus(3'b000, 12'h003, 3'b000, 1, "pat_drop");
      applyStimulus(3'b001, 12'h003, 3'b000, 1, "pat_reraise");
      checkValue("pat_new_led", int'(led), 3);

      r_req = 3'b000;
      r_pat = 12'h000;
      r_blk = 3'b000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) r_req = 3'($urandom);
         r_pat = 12'($urandom);
         if ($urandom_range(0, 7) == 0) r_blk = 3'($urandom);
         applyStimulus(r_req, r_pat, r_blk, 1, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
